fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined core. Holds the PC, issues one instruction-memory request at a time, buffers the returned word, and presents instruction, PC+2 and error status to the IF/ID pipeline register. It honours hazard stalls, branch/jump redirects from later stages, and a sticky halt.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_if.sv | 10 +
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

   localparam logic [15:0] NOP_INST    = 16'h0800;
   localparam logic [4:0]  HALT_OPCODE = 5'b00000;

   function automatic logic is_halt(input logic [15:0] inst);
      return inst[15:11] == HALT_OPCODE;
   endfunction
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid;
   logic [15:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with write enable and a free-running +2 adder.
module fetch_pc_reg #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [15:0] wr_pc,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2
);
   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (wr_en) pc_d = wr_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) pc_q <= RESET_PC;
      else      pc_q <= pc_d;
   end

   assign pc       = pc_q;
   assign pc_plus2 = pc_q + 16'd2;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, stall/redirect/halt.
// Define FETCH_TIMEOUT_EN to halt with an error when imem stops responding.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC       = 16'h0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   fetch_if.master     imem,
   output logic [15:0] PCAdd2Out,
   output logic [15:0] InstOut,
   output logic        validOut,
   output logic        errOut,
   output logic        halted
);
   fetch_state_e state_q, state_d;
   logic         kill_q, kill_d, kill_rst;
   logic [15:0]  inst_buf_q, inst_buf_d;
   logic         err_q, err_d;
   logic         pc_we;
   logic [15:0]  pc_wdata, pc, pc_plus2;
   logic         req;
   logic         tmo_hit;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (pc_we),
      .wr_pc    (pc_wdata),
      .pc       (pc),
      .pc_plus2 (pc_plus2)
   );

   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      inst_buf_d = inst_buf_q;
      err_d      = err_q;
      pc_we      = 1'b0;
      pc_wdata   = pc_plus2;
      req        = 1'b0;
      tmo_hit    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_d = '0;
      if (state_q == WAIT && !imem.imem_valid) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         tmo_hit   = (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES));
      end
`endif

      case (state_q)
         ISSUE: begin
            // A response still owed from before reset must drain before a new request.
            if (kill_q && imem.imem_valid) kill_d = 1'b0;
            if (redirect_en) begin
               pc_we    = 1'b1;
               pc_wdata = redirect_pc;
            end else if (!kill_q) begin
               if (pc[0]) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  req     = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (redirect_en) begin
               pc_we    = 1'b1;
               pc_wdata = redirect_pc;
            end
            if (imem.imem_valid) begin
               kill_d  = 1'b0;
               state_d = ISSUE;
               if (!kill_q && !redirect_en) begin
                  inst_buf_d = imem.imem_rdata;
                  state_d    = HOLD;
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else if (redirect_en) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_en) begin
               pc_we    = 1'b1;
               pc_wdata = redirect_pc;
               state_d  = ISSUE;
            end else if (!stall) begin
               pc_we   = 1'b1;
               state_d = is_halt(inst_buf_q) ? HALT : ISSUE;
            end
         end
         HALT: ;
      endcase

`ifdef FETCH_TIMEOUT_EN
      if (state_d != WAIT) tmo_cnt_d = '0;
`endif
   end

   // Remember an outstanding response across reset so it is discarded afterwards.
   assign kill_rst = ~imem.imem_valid & (kill_q | (state_q == WAIT));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ISSUE;
         kill_q     <= kill_rst;
         inst_buf_q <= NOP_INST;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         inst_buf_q <= inst_buf_d;
         err_q      <= err_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) tmo_cnt_q <= '0;
      else      tmo_cnt_q <= tmo_cnt_d;
   end
`endif

   assign imem.imem_req  = req & rst;
   assign imem.imem_addr = pc;
   assign validOut       = (state_q == HOLD) & ~redirect_en & rst;
   assign InstOut        = validOut ? inst_buf_q : NOP_INST;
   assign PCAdd2Out      = pc_plus2;
   assign errOut         = err_q & rst;
   assign halted         = (state_q == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem model with latency queue, address and
// instruction expectations queued by each scenario and checked by a monitor.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_en = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic [15:0] PCAdd2Out, InstOut;
   logic        validOut, errOut, halted;

   fetch_if imem ();

   fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .imem        (imem),
      .PCAdd2Out   (PCAdd2Out),
      .InstOut     (InstOut),
      .validOut    (validOut),
      .errOut      (errOut),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] exp_addr_q[$];
   logic [31:0] exp_inst_q[$];
   logic [15:0] mem [logic [15:0]];
   logic [15:0] pq_addr[$];
   int          pq_due[$];
   int          cyc = 0;
   int          lat = 1;
   bit          mute = 1'b0;
   bit          chk_en = 1'b0;

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'h4000;
   endfunction

   // imem model: in-order responses, each 'lat' cycles after its request.
   initial begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (imem.imem_req && !mute) begin
            pq_addr.push_back(imem.imem_addr);
            pq_due.push_back(cyc + lat);
         end
         @(posedge clk);
         #1;
         cyc++;
         imem.imem_valid = 1'b0;
         if (pq_due.size() != 0 && pq_due[0] <= cyc) begin
            imem.imem_valid = 1'b1;
            imem.imem_rdata = mem_rd(pq_addr.pop_front());
            void'(pq_due.pop_front());
         end
      end
   end

   // Monitor: every request and every new instruction is popped from the scoreboard.
   initial begin
      logic        vld_prev;
      logic [15:0] ea;
      logic [31:0] ei;
      vld_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en && rst) begin
            if (imem.imem_req) begin
               vectors++;
               if (exp_addr_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL req_addr: unexpected request addr=%h", imem.imem_addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (imem.imem_addr !== ea) begin
                     miscompares++;
                     $display("FAIL req_addr: got %h want %h", imem.imem_addr, ea);
                  end
               end
            end
            if (validOut && !vld_prev) begin
               vectors++;
               if (exp_inst_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL inst: unexpected valid inst=%h pc2=%h", InstOut, PCAdd2Out);
               end else begin
                  ei = exp_inst_q.pop_front();
                  if ({InstOut, PCAdd2Out} !== ei) begin
                     miscompares++;
                     $display("FAIL inst: got inst=%h pc2=%h want inst=%h pc2=%h",
                              InstOut, PCAdd2Out, ei[31:16], ei[15:0]);
                  end
               end
            end
         end
         vld_prev = validOut;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reset, letting any outstanding imem response drain while reset is held.
   task automatic do_reset;
      chk_en = 1'b0;
      stall = 1'b0;
      redirect_en = 1'b0;
      rst = 1'b0;
      exp_addr_q.delete();
      exp_inst_q.delete();
      step();
      for (int i = 0; i < 60 && (pq_due.size() != 0 || imem.imem_valid); i++) step();
      if (pq_due.size() != 0 || imem.imem_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL reset_drain: %0d responses still pending, want 0", pq_due.size());
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
      vectors++; if (imem.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr: got %h want 0000", imem.imem_addr); end
      vectors++; if (PCAdd2Out !== 16'h0002) begin miscompares++; $display("FAIL rst_pc2: got %h want 0002", PCAdd2Out); end
      vectors++; if (InstOut !== 16'h0800) begin miscompares++; $display("FAIL rst_inst: got %h want 0800", InstOut); end
      vectors++; if (validOut !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", validOut); end
      vectors++; if (errOut !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", errOut); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
   endtask

   task automatic test_free_run;
      logic [8:0] vmask;
      do_reset();
      exp_addr_q = '{16'h0000, 16'h0002, 16'h0004};
      exp_inst_q = '{{16'h4000, 16'h0002}, {16'h4000, 16'h0004}, {16'h4000, 16'h0006}};
      chk_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         vmask[i] = validOut;
      end
      #1 chk_en = 1'b0;
      vectors++;
      if (vmask !== 9'b100100100) begin
         miscompares++;
         $display("FAIL free_run_cadence: got %b want 100100100", vmask);
      end
      vectors++;
      if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
         miscompares++;
         $display("FAIL free_run_drain: got %0d/%0d left want 0/0", exp_addr_q.size(), exp_inst_q.size());
      end
   endtask

   task automatic test_stall;
      do_reset();
      exp_addr_q = '{16'h0000, 16'h0002};
      exp_inst_q = '{{16'h4000, 16'h0002}};
      chk_en = 1'b1;
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({validOut, imem.imem_req, InstOut, PCAdd2Out} !== {1'b1, 1'b0, 16'h4000, 16'h0002}) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b req=%b inst=%h pc2=%h want v=1 req=0 inst=4000 pc2=0002",
                     validOut, imem.imem_req, InstOut, PCAdd2Out);
         end
         step();
      end
      stall = 1'b0;
      step();
      @(negedge clk);
      vectors++;
      if ({imem.imem_req, PCAdd2Out} !== {1'b1, 16'h0004}) begin
         miscompares++;
         $display("FAIL stall_release: got req=%b pc2=%h want req=1 pc2=0004", imem.imem_req, PCAdd2Out);
      end
      #1 chk_en = 1'b0;
      vectors++;
      if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_drain: got %0d/%0d left want 0/0", exp_addr_q.size(), exp_inst_q.size());
      end
   endtask

   task automatic test_redirect;
      do_reset();
      lat = 3;
      exp_addr_q = '{16'h0000, 16'h0100};
      exp_inst_q = '{{16'h6A01, 16'h0102}};
      chk_en = 1'b1;
      step();
      redirect_en = 1'b1;
      redirect_pc = 16'h0100;
      step();
      redirect_en = 1'b0;
      lat = 1;
      for (int c = 3; c <= 7; c++) begin
         @(negedge clk);
         vectors++;
         if (validOut !== (c == 7)) begin
            miscompares++;
            $display("FAIL redirect_valid: cycle %0d got %b want %b", c, validOut, (c == 7));
         end
         if (c != 7) step();
      end
      #1 chk_en = 1'b0;
      vectors++;
      if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
         miscompares++;
         $display("FAIL redirect_drain: got %0d/%0d left want 0/0", exp_addr_q.size(), exp_inst_q.size());
      end
   endtask

   task automatic test_misaligned;
      do_reset();
      chk_en = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 16'h0011;
      @(negedge clk);
      vectors++;
      if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_redirect_req: got %b want 0", imem.imem_req); end
      step();
      redirect_en = 1'b0;
      @(negedge clk);
      vectors++;
      if ({imem.imem_req, errOut, halted} !== 3'b000) begin
         miscompares++;
         $display("FAIL mis_issue: got req/err/halt=%b%b%b want 000", imem.imem_req, errOut, halted);
      end
      step();
      @(negedge clk);
      vectors++;
      if ({errOut, halted, validOut} !== 3'b110) begin
         miscompares++;
         $display("FAIL mis_halt: got err/halt/valid=%b%b%b want 110", errOut, halted, validOut);
      end
      step();
      chk_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (errOut !== 1'b0) begin miscompares++; $display("FAIL mis_rst_err: got %b want 0", errOut); end
      step();
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({errOut, halted} !== 2'b00) begin
         miscompares++;
         $display("FAIL mis_after_rst: got err/halt=%b%b want 00", errOut, halted);
      end
   endtask

   task automatic test_halt;
      do_reset();
      mem[16'h0200] = 16'h0000;
      exp_addr_q = '{16'h0200};
      exp_inst_q = '{{16'h0000, 16'h0202}};
      chk_en = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 16'h0200;
      step();
      redirect_en = 1'b0;
      step();
      step();
      @(negedge clk);
      vectors++;
      if (validOut !== 1'b1) begin miscompares++; $display("FAIL halt_word_valid: got %b want 1", validOut); end
      step();
      redirect_en = 1'b1;
      redirect_pc = 16'h0300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({halted, validOut, imem.imem_req, imem.imem_addr} !== {3'b100, 16'h0202}) begin
            miscompares++;
            $display("FAIL halt_sticky: got halt=%b v=%b req=%b addr=%h want halt=1 v=0 req=0 addr=0202",
                     halted, validOut, imem.imem_req, imem.imem_addr);
         end
         step();
      end
      redirect_en = 1'b0;
      chk_en = 1'b0;
      vectors++;
      if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
         miscompares++;
         $display("FAIL halt_drain: got %0d/%0d left want 0/0", exp_addr_q.size(), exp_inst_q.size());
      end
   endtask

   task automatic test_reset_mid_fetch;
      do_reset();
      mem[16'h0040] = 16'h7777;
      lat = 4;
      exp_addr_q = '{16'h0040, 16'h0000};
      exp_inst_q = '{{16'h4000, 16'h0002}};
      chk_en = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect_en = 1'b0;
      step();
      rst = 1'b0;
      lat = 1;
      step();
      rst = 1'b1;
      for (int c = 4; c <= 9; c++) begin
         @(negedge clk);
         vectors++;
         if (validOut !== (c == 9)) begin
            miscompares++;
            $display("FAIL midrst_valid: cycle %0d got %b want %b", c, validOut, (c == 9));
         end
         if (c != 9) step();
      end
      #1 chk_en = 1'b0;
      vectors++;
      if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_drain: got %0d/%0d left want 0/0", exp_addr_q.size(), exp_inst_q.size());
      end
   endtask

   // Memory never answers, so this scenario must run last.
   task automatic test_timeout;
      do_reset();
      mute = 1'b1;
      exp_addr_q = '{16'h0000};
      chk_en = 1'b1;
      for (int c = 2; c <= 5; c++) begin
         step();
         @(negedge clk);
         vectors++;
         if ({errOut, halted} !== 2'b00) begin
            miscompares++;
            $display("FAIL tmo_wait: cycle %0d got err/halt=%b%b want 00", c, errOut, halted);
         end
      end
      step();
      @(negedge clk);
      vectors++;
`ifdef FETCH_TIMEOUT_EN
      if ({errOut, halted} !== 2'b11) begin
         miscompares++;
         $display("FAIL tmo_fire: got err/halt=%b%b want 11", errOut, halted);
      end
`else
      if ({errOut, halted, validOut} !== 3'b000) begin
         miscompares++;
         $display("FAIL tmo_none: got err/halt/valid=%b%b%b want 000", errOut, halted, validOut);
      end
      repeat (20) step();
      @(negedge clk);
      vectors++;
      if ({errOut, halted, imem.imem_req} !== 3'b000) begin
         miscompares++;
         $display("FAIL tmo_none_long: got err/halt/req=%b%b%b want 000", errOut, halted, imem.imem_req);
      end
`endif
      #1 chk_en = 1'b0;
      vectors++;
      if (exp_addr_q.size() != 0) begin
         miscompares++;
         $display("FAIL tmo_drain: got %0d left want 0", exp_addr_q.size());
      end
   endtask

   initial begin
      mem[16'h0000] = 16'h4000;
      mem[16'h0002] = 16'h4000;
      mem[16'h0100] = 16'h6A01;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_misaligned();
      test_halt();
      test_reset_mid_fetch();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
